vga_fb_arbiter: RTL and testbench

Single-port frame-buffer arbiter for the VGA pipeline. It shares one synchronous-read pixel RAM between two requesters: the display scan-out reader, which has priority, and a pixel writer used for host or drawing updates. It registers all RAM control, returns read data with fixed latency, and guarantees the writer a slot after a bounded run of display reads. It sits between the VGA timing/scan-out logic and the RGB frame-buffer RAM.

---
 rtl/vga_fb_arbiter.sv | 135 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Single-port frame-buffer arbiter. Display scan-out reads take
//               priority over pixel writes. FB_WR_STARVE_GUARD_EN enables a
//               forced write slot after MAX_DISP_BURST display grants.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int DATA_WIDTH     = 24,
    parameter int PIXELS         = 307200,
    parameter int ADDR_WIDTH     = $clog2(PIXELS),
    parameter int MAX_DISP_BURST = 8
) (
    input  logic                  clock,
    input  logic                  neg_reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  wr_oob,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // One extra bit so PIXELS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] c_pixels = (ADDR_WIDTH+1)'(PIXELS);

    if (MAX_DISP_BURST < 1) begin : g_burst_check
        $error("MAX_DISP_BURST must be at least 1");
    end

    logic                  w_disp_hs;
    logic                  w_wr_hs;
    logic                  w_disp_in;
    logic                  w_wr_in;

    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_wr_oob;
    logic                  r_p1_valid;
    logic                  r_p1_oob;
    logic                  r_rvalid;
    logic                  r_roob;

    assign w_disp_in = ({1'b0, disp_addr} < c_pixels);
    assign w_wr_in   = ({1'b0, wr_addr} < c_pixels);
    assign w_disp_hs = disp_req & disp_gnt;
    assign w_wr_hs   = wr_valid & wr_ready;

`ifdef FB_WR_STARVE_GUARD_EN
    localparam int                  c_cnt_w     = $clog2(MAX_DISP_BURST + 1);
    localparam logic [c_cnt_w-1:0]  c_burst_max = c_cnt_w'(MAX_DISP_BURST);

    logic [c_cnt_w-1:0] r_burst_cnt;
    logic               w_force_wr;

    assign w_force_wr = wr_valid & (r_burst_cnt == c_burst_max);

    always_comb begin
        disp_gnt = disp_req & ~w_force_wr;
        wr_ready = wr_valid & (~disp_req | w_force_wr);
    end

    // Counts display grants made while a write waits; any write grant or idle
    // writer restarts the run.
    always_ff @(posedge clock or negedge neg_reset) begin
        if (!neg_reset) begin
            r_burst_cnt <= '0;
        end else if (!wr_valid || w_wr_hs) begin
            r_burst_cnt <= '0;
        end else if (w_disp_hs && (r_burst_cnt != c_burst_max)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        disp_gnt = disp_req;
        wr_ready = wr_valid & ~disp_req;
    end
`endif

    always_ff @(posedge clock or negedge neg_reset) begin
        if (!neg_reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_oob    <= 1'b0;
            r_p1_valid  <= 1'b0;
            r_p1_oob    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_roob      <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_p1_valid <= w_disp_hs;
            r_p1_oob   <= w_disp_hs & ~w_disp_in;
            r_rvalid   <= r_p1_valid;
            r_roob     <= r_p1_oob;
            if (w_disp_hs) begin
                r_mem_en   <= w_disp_in;
                r_mem_addr <= disp_addr;
            end else if (w_wr_hs) begin
                r_mem_en    <= w_wr_in;
                r_mem_we    <= w_wr_in;
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end
            if (w_wr_hs && !w_wr_in) begin
                r_wr_oob <= 1'b1;
            end
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wr_oob      = r_wr_oob;
    assign disp_rvalid = r_rvalid;
    assign disp_rdata  = r_roob ? '0 : mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Directed self-checking bench for vga_fb_arbiter with a
//               synchronous-read RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int c_dw = 24;
    localparam int c_aw = 19;
`ifdef FB_WR_STARVE_GUARD_EN
    localparam int c_exp_wr_cycle = 8;
    localparam int c_exp_disp_grants = 19;
`else
    localparam int c_exp_wr_cycle = 20;
    localparam int c_exp_disp_grants = 20;
`endif

    logic            clock;
    logic            neg_reset;
    logic            disp_req;
    logic [c_aw-1:0] disp_addr;
    logic            disp_gnt;
    logic            disp_rvalid;
    logic [c_dw-1:0] disp_rdata;
    logic            wr_valid;
    logic [c_aw-1:0] wr_addr;
    logic [c_dw-1:0] wr_data;
    logic            wr_ready;
    logic            wr_oob;
    logic            mem_en;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [c_dw-1:0] ram [0:307199];

    vga_fb_arbiter u_dut (
        .clock       (clock),
        .neg_reset   (neg_reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_oob      (wr_oob),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", disp_rvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL reset_wr_oob got=%b exp=0", wr_oob); end
        @(posedge clock);
        @(negedge clock);
        neg_reset = 1'b1;
    endtask

    task automatic test_single_read();
        tick(); disp_req = 1'b1; disp_addr = 19'd100; #1;
        checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b exp=1", disp_gnt); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL single_wr_ready got=%b exp=0", wr_ready); end
        tick(); disp_req = 1'b0; #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL single_issue en=%b we=%b exp en=1 we=0", mem_en, mem_we); end
        checks++; if (mem_addr !== 19'd100) begin errors++; $display("FAIL single_addr got=%0d exp=100", mem_addr); end
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got=%b exp=0", disp_rvalid); end
        tick(); #1;
        checks++; if (disp_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got=%b exp=1", disp_rvalid); end
        checks++; if (disp_rdata !== 24'hFF8000) begin errors++; $display("FAIL single_rdata got=%h exp=ff8000", disp_rdata); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL single_en_clear got=%b exp=0", mem_en); end
        tick(); #1;
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_clear got=%b exp=0", disp_rvalid); end
    endtask

    task automatic test_write_then_read();
        tick(); wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 24'h00FF00; #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b exp=1", wr_ready); end
        checks++; if (disp_gnt !== 1'b0) begin errors++; $display("FAIL wr_disp_gnt got=%b exp=0", disp_gnt); end
        tick(); wr_valid = 1'b0; #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_issue en=%b we=%b exp en=1 we=1", mem_en, mem_we); end
        checks++; if (mem_addr !== 19'd5) begin errors++; $display("FAIL wr_addr got=%0d exp=5", mem_addr); end
        checks++; if (mem_wdata !== 24'h00FF00) begin errors++; $display("FAIL wr_wdata got=%h exp=00ff00", mem_wdata); end
        tick(); disp_req = 1'b1; disp_addr = 19'd5; #1;
        checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL raw_gnt got=%b exp=1", disp_gnt); end
        tick(); disp_req = 1'b0;
        tick(); #1;
        checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 24'h00FF00) begin errors++; $display("FAIL raw_rdata v=%b d=%h exp v=1 d=00ff00", disp_rvalid, disp_rdata); end
    endtask

    task automatic test_out_of_range();
        tick(); wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 24'hABCDEF; #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_wr_ready got=%b exp=1", wr_ready); end
        tick(); wr_valid = 1'b0; #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL oob_wr_issue en=%b we=%b exp 0 0", mem_en, mem_we); end
        checks++; if (wr_oob !== 1'b1) begin errors++; $display("FAIL oob_flag got=%b exp=1", wr_oob); end
        tick(); disp_req = 1'b1; disp_addr = 19'd307201; #1;
        checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL oob_rd_gnt got=%b exp=1", disp_gnt); end
        tick(); disp_req = 1'b0; #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL oob_rd_en got=%b exp=0", mem_en); end
        tick(); #1;
        checks++; if (disp_rvalid !== 1'b1) begin errors++; $display("FAIL oob_rd_rvalid got=%b exp=1", disp_rvalid); end
        checks++; if (disp_rdata !== 24'h000000) begin errors++; $display("FAIL oob_rd_rdata got=%h exp=000000", disp_rdata); end
        tick(); tick(); #1;
        checks++; if (wr_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky got=%b exp=1", wr_oob); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 4) begin disp_req = 1'b1; disp_addr = 19'(200 + c); end
            else disp_req = 1'b0;
            #1;
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_en !== 1'b1 || mem_addr !== 19'(199 + c)) begin errors++; $display("FAIL b2b_issue c=%0d en=%b addr=%0d exp addr=%0d", c, mem_en, mem_addr, 199 + c); end
            end
            if (c >= 2) begin
                checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== (24'h112200 + 24'(c - 2))) begin errors++; $display("FAIL b2b_rdata c=%0d v=%b d=%h exp=%h", c, disp_rvalid, disp_rdata, 24'h112200 + 24'(c - 2)); end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        tick(); disp_req = 1'b1; disp_addr = 19'd100;
        tick(); disp_addr = 19'd101;
        tick(); disp_req = 1'b0;
        #2; neg_reset = 1'b0; #1;
        checks++; if (disp_rvalid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL midrst_outputs v=%b en=%b exp 0 0", disp_rvalid, mem_en); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL midrst_mem addr=%0d wdata=%h exp 0 0", mem_addr, mem_wdata); end
        checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL midrst_wr_oob got=%b exp=0", wr_oob); end
        @(posedge clock);
        @(negedge clock);
        neg_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_stale_rvalid c=%0d got=%b exp=0", c, disp_rvalid); end
        end
    endtask

    task automatic test_guard_priority();
        int k = 0;
        int wr_cycle = -1;
        bit wr_pend = 1'b1;
        bit g1 = 1'b0;
        bit g2 = 1'b0;
        bit exp_wr;
        bit exp_dg;
        logic [c_dw-1:0] expq[$];
        logic [c_dw-1:0] exp_d;
        for (int c = 0; c < 24; c++) begin
            tick();
            checks++; if (disp_rvalid !== g2) begin errors++; $display("FAIL guard_rvalid c=%0d got=%b exp=%b", c, disp_rvalid, g2); end
            if (g2 && expq.size() > 0) begin
                exp_d = expq.pop_front();
                checks++; if (disp_rdata !== exp_d) begin errors++; $display("FAIL guard_rdata c=%0d got=%h exp=%h", c, disp_rdata, exp_d); end
            end
            disp_req  = (c < 20);
            disp_addr = 19'(300 + k);
            wr_valid  = wr_pend;
            wr_addr   = 19'd7;
            wr_data   = 24'h123456;
            #1;
            exp_wr = wr_pend && (c == c_exp_wr_cycle || c >= 20);
            exp_dg = (c < 20) && !exp_wr;
            checks++; if (disp_gnt !== exp_dg) begin errors++; $display("FAIL guard_disp_gnt c=%0d got=%b exp=%b", c, disp_gnt, exp_dg); end
            checks++; if (wr_ready !== exp_wr) begin errors++; $display("FAIL guard_wr_ready c=%0d got=%b exp=%b", c, wr_ready, exp_wr); end
            if (exp_dg) begin
                expq.push_back(24'hA50000 + 24'(k));
                k++;
            end
            if (exp_wr) begin
                wr_pend  = 1'b0;
                wr_cycle = c;
            end
            g2 = g1;
            g1 = exp_dg;
        end
        disp_req = 1'b0;
        wr_valid = 1'b0;
        checks++; if (wr_cycle != c_exp_wr_cycle) begin errors++; $display("FAIL guard_wr_cycle got=%0d exp=%0d", wr_cycle, c_exp_wr_cycle); end
        checks++; if (k != c_exp_disp_grants || expq.size() != 0) begin errors++; $display("FAIL guard_grant_count got=%0d left=%0d exp=%0d left=0", k, expq.size(), c_exp_disp_grants); end
        tick(); disp_req = 1'b1; disp_addr = 19'd7;
        tick(); disp_req = 1'b0;
        tick(); #1;
        checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 24'h123456) begin errors++; $display("FAIL guard_wr_landed v=%b d=%h exp v=1 d=123456", disp_rvalid, disp_rdata); end
    endtask

    initial begin
        neg_reset = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        ram[100] = 24'hFF8000;
        for (int i = 0; i < 4; i++) ram[200 + i] = 24'h112200 + 24'(i);
        for (int i = 0; i < 24; i++) ram[300 + i] = 24'hA50000 + 24'(i);
        test_reset();
        test_single_read();
        test_write_then_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        test_guard_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
